// File: rtl/i2c_target_fifo.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_fifo
// Brief    : Clock-sampled I2C target with RX/TX FIFOs. Optional SCL clock
//            stretching is enabled by defining I2C_TARGET_CLK_STRETCH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_target_fifo #(
    parameter int ADDR_WIDTH  = 7,
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    output logic                  scl_oe,
    input  logic [ADDR_WIDTH-1:0] own_addr,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_ready,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  last_rw,
    output logic                  xfer_done,
    output logic                  nack_rcvd,
    output logic                  rx_overflow,
    output logic                  tx_underflow
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_SW = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
    localparam int c_BW = $clog2(c_SW + 1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ADDR     = 3'd1;
    localparam logic [2:0] c_ADDR_ACK = 3'd2;
    localparam logic [2:0] c_WR_DATA  = 3'd3;
    localparam logic [2:0] c_WR_ACK   = 3'd4;
    localparam logic [2:0] c_RD_DATA  = 3'd5;
    localparam logic [2:0] c_RD_ACK   = 3'd6;
    localparam logic [2:0] c_IGNORE   = 3'd7;

    // ------------------------------------------------------------------
    // Pin synchronisers and bus event detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
    logic                   r_scl_prev, r_sda_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
            r_scl_prev <= r_scl_sync[SYNC_STAGES-1];
            r_sda_prev <= r_sda_sync[SYNC_STAGES-1];
        end
    end

    logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise = w_scl & ~r_scl_prev;
    assign w_scl_fall = ~w_scl & r_scl_prev;
    assign w_start    = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign w_stop     = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

    // ------------------------------------------------------------------
    // RX FIFO (bus -> user)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_rx_mem [FIFO_DEPTH];
    logic [c_PW-1:0]       r_rx_wp, r_rx_rp;
    logic [c_CW-1:0]       r_rx_cnt;
    logic                  w_rx_full, w_rx_pop, w_rx_push, w_rx_space;
    logic [c_SW-1:0]       r_shift;

    assign w_rx_full  = (r_rx_cnt == c_CW'(FIFO_DEPTH));
    assign rx_valid   = (r_rx_cnt != '0);
    assign rx_data    = r_rx_mem[r_rx_rp];
    assign w_rx_pop   = rx_valid & rx_ready;
    assign w_rx_space = ~w_rx_full | w_rx_pop;

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= r_shift[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_wp  <= '0;
            r_rx_rp  <= '0;
            r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_PW'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_PW'(1);
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + c_CW'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - c_CW'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO (user -> bus); an empty FIFO forwards a same-clock push
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_tx_mem [FIFO_DEPTH];
    logic [c_PW-1:0]       r_tx_wp, r_tx_rp;
    logic [c_CW-1:0]       r_tx_cnt;
    logic                  w_tx_empty, w_tx_push, w_tx_pop, w_tx_avail;
    logic [DATA_WIDTH-1:0] w_tx_word;

    assign w_tx_empty = (r_tx_cnt == '0);
    assign tx_ready   = (r_tx_cnt != c_CW'(FIFO_DEPTH));
    assign w_tx_push  = tx_valid & tx_ready;
    assign w_tx_avail = ~w_tx_empty | w_tx_push;
    assign w_tx_word  = w_tx_empty ? tx_data : r_tx_mem[r_tx_rp];

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_wp  <= '0;
            r_tx_rp  <= '0;
            r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_PW'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_PW'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + c_CW'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - c_CW'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    logic [2:0]      r_state, w_state_nx;
    logic [c_BW-1:0] r_bitcnt, w_bitcnt_nx;
    logic [c_SW-1:0] w_shift_nx;
    logic r_sda_oe, w_sda_oe_nx, r_scl_oe, w_scl_oe_nx;
    logic r_busy, w_busy_nx, r_last_rw, w_last_rw_nx, r_matched, w_matched_nx;
    logic r_xfer_done, w_xfer_done_nx, r_nack, w_nack_nx;
    logic r_ovf, w_ovf_nx, r_unf, w_unf_nx;
    logic r_pend, w_pend_nx, r_rel, w_rel_nx;
    logic w_rd_load, w_wr_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_sda_oe    <= 1'b0;
            r_scl_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_last_rw   <= 1'b0;
            r_matched   <= 1'b0;
            r_xfer_done <= 1'b0;
            r_nack      <= 1'b0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_pend      <= 1'b0;
            r_rel       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_bitcnt    <= w_bitcnt_nx;
            r_shift     <= w_shift_nx;
            r_sda_oe    <= w_sda_oe_nx;
            r_scl_oe    <= w_scl_oe_nx;
            r_busy      <= w_busy_nx;
            r_last_rw   <= w_last_rw_nx;
            r_matched   <= w_matched_nx;
            r_xfer_done <= w_xfer_done_nx;
            r_nack      <= w_nack_nx;
            r_ovf       <= w_ovf_nx;
            r_unf       <= w_unf_nx;
            r_pend      <= w_pend_nx;
            r_rel       <= w_rel_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_bitcnt_nx    = r_bitcnt;
        w_shift_nx     = r_shift;
        w_sda_oe_nx    = r_sda_oe;
        w_scl_oe_nx    = r_scl_oe;
        w_busy_nx      = r_busy;
        w_last_rw_nx   = r_last_rw;
        w_matched_nx   = r_matched;
        w_xfer_done_nx = 1'b0;
        w_nack_nx      = 1'b0;
        w_ovf_nx       = 1'b0;
        w_unf_nx       = 1'b0;
        w_pend_nx      = r_pend;
        w_rel_nx       = 1'b0;
        w_rx_push      = 1'b0;
        w_tx_pop       = 1'b0;
        w_rd_load      = 1'b0;
        w_wr_ack       = 1'b0;

        // SCL is let go one clock after SDA was set up for the stretched slot
        if (r_rel) w_scl_oe_nx = 1'b0;

        case (r_state)
            c_ADDR: begin
                if (w_scl_rise) begin
                    w_shift_nx  = {r_shift[c_SW-2:0], w_sda};
                    w_bitcnt_nx = r_bitcnt + c_BW'(1);
                end else if (w_scl_fall && r_bitcnt == c_BW'(ADDR_WIDTH + 1)) begin
                    if (r_shift[ADDR_WIDTH:1] == own_addr) begin
                        w_state_nx   = c_ADDR_ACK;
                        w_sda_oe_nx  = 1'b1;
                        w_last_rw_nx = r_shift[0];
                        w_matched_nx = 1'b1;
                    end else begin
                        w_state_nx = c_IGNORE;
                    end
                end
            end
            c_ADDR_ACK: begin
                if (w_scl_fall) begin
                    w_sda_oe_nx = 1'b0;
                    w_bitcnt_nx = '0;
                    if (r_last_rw) w_rd_load  = 1'b1;
                    else           w_state_nx = c_WR_DATA;
                end
            end
            c_WR_DATA: begin
                if (w_scl_rise) begin
                    w_shift_nx  = {r_shift[c_SW-2:0], w_sda};
                    w_bitcnt_nx = r_bitcnt + c_BW'(1);
                end else if (w_scl_fall && r_bitcnt == c_BW'(DATA_WIDTH)) begin
                    w_state_nx = c_WR_ACK;
                    w_wr_ack   = 1'b1;
                end
            end
            c_WR_ACK: begin
                if (r_pend) begin
                    if (w_rx_space) begin
                        w_rx_push   = 1'b1;
                        w_sda_oe_nx = 1'b1;
                        w_pend_nx   = 1'b0;
                        w_rel_nx    = 1'b1;
                    end
                end else if (w_scl_fall) begin
                    w_state_nx  = c_WR_DATA;
                    w_sda_oe_nx = 1'b0;
                    w_bitcnt_nx = '0;
                end
            end
            c_RD_DATA: begin
                if (r_pend) begin
                    if (w_tx_avail) w_rd_load = 1'b1;
                end else if (w_scl_fall) begin
                    if (r_bitcnt == c_BW'(DATA_WIDTH)) begin
                        w_state_nx  = c_RD_ACK;
                        w_sda_oe_nx = 1'b0;
                    end else begin
                        w_shift_nx  = r_shift << 1;
                        w_sda_oe_nx = ~r_shift[DATA_WIDTH-2];
                        w_bitcnt_nx = r_bitcnt + c_BW'(1);
                    end
                end
            end
            c_RD_ACK: begin
                if (w_scl_rise && w_sda) begin
                    w_nack_nx  = 1'b1;
                    w_state_nx = c_IGNORE;
                end else if (w_scl_fall) begin
                    w_rd_load = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_wr_ack) begin
            if (w_rx_space) begin
                w_rx_push   = 1'b1;
                w_sda_oe_nx = 1'b1;
            end else begin
                w_sda_oe_nx = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                w_scl_oe_nx = 1'b1;
                w_pend_nx   = 1'b1;
`else
                w_ovf_nx    = 1'b1;
`endif
            end
        end

        // First data bit goes on SDA in the same clock the word is fetched
        if (w_rd_load) begin
            w_state_nx  = c_RD_DATA;
            w_bitcnt_nx = c_BW'(1);
            if (w_tx_avail) begin
                w_tx_pop    = 1'b1;
                w_shift_nx  = c_SW'(w_tx_word);
                w_sda_oe_nx = ~w_tx_word[DATA_WIDTH-1];
                if (r_pend) begin
                    w_pend_nx = 1'b0;
                    w_rel_nx  = 1'b1;
                end
            end else begin
                w_sda_oe_nx = 1'b0;
`ifdef I2C_TARGET_CLK_STRETCH_EN
                w_scl_oe_nx = 1'b1;
                w_pend_nx   = 1'b1;
`else
                w_shift_nx  = '1;
                w_unf_nx    = 1'b1;
`endif
            end
        end

        // Bus conditions override whatever the byte engine was doing
        if (w_start || w_stop) begin
            w_state_nx     = w_start ? c_ADDR : c_IDLE;
            w_busy_nx      = w_start;
            w_bitcnt_nx    = '0;
            w_sda_oe_nx    = 1'b0;
            w_scl_oe_nx    = 1'b0;
            w_pend_nx      = 1'b0;
            w_rel_nx       = 1'b0;
            w_rx_push      = 1'b0;
            w_tx_pop       = 1'b0;
            w_nack_nx      = 1'b0;
            w_ovf_nx       = 1'b0;
            w_unf_nx       = 1'b0;
            w_xfer_done_nx = r_matched;
            w_matched_nx   = 1'b0;
        end
    end

    assign sda_oe       = r_sda_oe;
`ifdef I2C_TARGET_CLK_STRETCH_EN
    assign scl_oe       = r_scl_oe;
`else
    assign scl_oe       = 1'b0;
`endif
    assign busy         = r_busy;
    assign last_rw      = r_last_rw;
    assign xfer_done    = r_xfer_done;
    assign nack_rcvd    = r_nack;
    assign rx_overflow  = r_ovf;
    assign tx_underflow = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_fifo
// Brief    : Bit-banged I2C master bench with scoreboards for the RX/TX paths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_target_fifo;

    localparam int c_Q = 80;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [6:0] own_addr = 7'h22;
    logic       rx_ready = 1'b0;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sda_oe, scl_oe, rx_valid, tx_ready, busy, last_rw;
    logic       xfer_done, nack_rcvd, rx_overflow, tx_underflow;
    logic [7:0] rx_data;
    wire        scl_line = scl_m & ~scl_oe;
    wire        sda_line = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target_fifo #(
        .ADDR_WIDTH (7),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (4),
        .SYNC_STAGES(2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .scl_i       (scl_line),
        .sda_i       (sda_line),
        .sda_oe      (sda_oe),
        .scl_oe      (scl_oe),
        .own_addr    (own_addr),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .last_rw     (last_rw),
        .xfer_done   (xfer_done),
        .nack_rcvd   (nack_rcvd),
        .rx_overflow (rx_overflow),
        .tx_underflow(tx_underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int c_xfer = 0, c_nack = 0, c_ovf = 0, c_unf = 0, c_oe = 0, c_busy_low = 0;
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (xfer_done)    c_xfer++;
            if (nack_rcvd)    c_nack++;
            if (rx_overflow)  c_ovf++;
            if (tx_underflow) c_unf++;
            if (sda_oe)       c_oe++;
            if (!busy)        c_busy_low++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic scl_high();
        scl_m = 1'b1;
        for (int i = 0; i < 400 && !scl_line; i++) @(negedge clk);
        if (!scl_line) begin
            n_tests++;
            n_fail++;
            $display("FAIL scl_release: actual 0 required 1");
        end
    endtask

    task automatic wbit(input logic b);
        sda_m = b;
        #(c_Q);
        scl_high();
        #(2 * c_Q);
        scl_m = 1'b0;
        #(c_Q);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1;
        #(c_Q);
        scl_high();
        #(c_Q);
        b = sda_line;
        #(c_Q);
        scl_m = 1'b0;
        #(c_Q);
    endtask

    // Serves both as first START (from idle) and repeated START (SCL low)
    task automatic i2c_start();
        sda_m = 1'b1;
        #(c_Q);
        scl_high();
        #(c_Q);
        sda_m = 1'b0;
        #(2 * c_Q);
        scl_m = 1'b0;
        #(c_Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0;
        #(c_Q);
        scl_high();
        #(c_Q);
        sda_m = 1'b1;
        #(2 * c_Q);
    endtask

    task automatic wbyte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(output logic [7:0] d, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            d[i] = b;
        end
        wbit(nack);
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_q.push_back(d);
    endtask

    task automatic drain_rx();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!rx_valid) break;
            if (rx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rx_extra: actual %0h required none", rx_data);
            end else begin
                check("rx_data", rx_data, rx_q.pop_front());
            end
            rx_ready = 1'b1;
            @(negedge clk);
            rx_ready = 1'b0;
        end
        check("rx_q_empty", rx_q.size(), 0);
    endtask

    typedef struct {
        logic [7:0] addr_rw;
        int         nw;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       exp_ack;
    } vec_t;

    initial begin
        vec_t       vecs[4];
        logic       ack;
        logic [7:0] d;
        logic [7:0] w;
        logic [2:0] bits;
        logic       b;
        int         xb, ob, nb, ub, vb, bl;

        vecs[0] = '{8'h44, 2, 8'hA5, 8'h3C, 1'b1};
        vecs[1] = '{8'h46, 2, 8'h12, 8'h34, 1'b0};
        vecs[2] = '{8'h44, 1, 8'h5A, 8'h00, 1'b1};
        vecs[3] = '{8'hC4, 1, 8'h77, 8'h00, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs",
              {sda_oe, scl_oe, busy, last_rw, rx_valid, xfer_done, nack_rcvd, rx_overflow, tx_underflow},
              9'b0);
        check("reset_tx_ready", tx_ready, 1'b1);
        #(2 * c_Q);

        // Write transactions from the vector table
        for (int v = 0; v < 4; v++) begin
            xb = c_xfer;
            ob = c_oe;
            i2c_start();
            check("busy_after_start", busy, 1'b1);
            wbyte(vecs[v].addr_rw, ack);
            check("addr_ack", ack, vecs[v].exp_ack);
            for (int k = 0; k < vecs[v].nw; k++) begin
                w = (k == 0) ? vecs[v].d0 : vecs[v].d1;
                wbyte(w, ack);
                check("data_ack", ack, vecs[v].exp_ack);
                if (vecs[v].exp_ack) rx_q.push_back(w);
            end
            i2c_stop();
            check("xfer_done_count", c_xfer - xb, vecs[v].exp_ack ? 1 : 0);
            check("busy_after_stop", busy, 1'b0);
            if (vecs[v].exp_ack) check("last_rw_write", last_rw, 1'b0);
            else                 check("no_sda_oe_on_miss", c_oe - ob, 0);
            drain_rx();
        end

        // Read two preloaded words, ACK then NACK
        push_tx(8'h11);
        push_tx(8'h22);
        nb = c_nack;
        xb = c_xfer;
        i2c_start();
        wbyte(8'h45, ack);
        check("rd_addr_ack", ack, 1'b1);
        check("last_rw_read", last_rw, 1'b1);
        rbyte(d, 1'b0);
        check("rd_word0", d, tx_q.pop_front());
        rbyte(d, 1'b1);
        check("rd_word1", d, tx_q.pop_front());
        i2c_stop();
        check("nack_count", c_nack - nb, 1);
        check("rd_xfer_done", c_xfer - xb, 1);

        // TX now empty: all-ones word and an underflow pulse
        ub = c_unf;
        i2c_start();
        wbyte(8'h45, ack);
        rbyte(d, 1'b1);
        i2c_stop();
        check("rd_empty_word", d, 8'hFF);
        check("underflow_count", c_unf - ub, 1);

        // Five writes into a four-deep RX FIFO with no draining
        vb = c_ovf;
        i2c_start();
        wbyte(8'h44, ack);
        for (int k = 0; k < 5; k++) begin
            w = 8'($urandom_range(0, 255));
            wbyte(w, ack);
            if (k < 4) begin
                check("ovf_word_ack", ack, 1'b1);
                rx_q.push_back(w);
            end else begin
                check("ovf_word_nack", ack, 1'b0);
            end
        end
        i2c_stop();
        check("overflow_count", c_ovf - vb, 1);
        drain_rx();

        // Write then repeated-START read
        push_tx(8'h77);
        i2c_start();
        bl = c_busy_low;
        wbyte(8'h44, ack);
        wbyte(8'h01, ack);
        check("rs_write_ack", ack, 1'b1);
        rx_q.push_back(8'h01);
        xb = c_xfer;
        i2c_start();
        check("rs_xfer_done", c_xfer - xb, 1);
        wbyte(8'h45, ack);
        check("rs_read_ack", ack, 1'b1);
        check("rs_last_rw", last_rw, 1'b1);
        rbyte(d, 1'b1);
        check("rs_read_word", d, tx_q.pop_front());
        check("rs_busy_held", c_busy_low - bl, 0);
        i2c_stop();
        check("rs_xfer_done_total", c_xfer - xb, 2);
        drain_rx();

        // Reset asserted while the target drives the fourth read bit
        push_tx(8'hA5);
        i2c_start();
        wbyte(8'h45, ack);
        for (int i = 2; i >= 0; i--) begin
            rbit(b);
            bits[i] = b;
        end
        check("mid_rd_bits", bits, 3'b101);
        check("mid_rd_sda_oe", sda_oe, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        sda_m = 1'b1;
        scl_high();
        #(2 * c_Q);
        void'(tx_q.pop_front());

        xb = c_xfer;
        i2c_start();
        wbyte(8'h44, ack);
        check("post_rst_addr_ack", ack, 1'b1);
        wbyte(8'h99, ack);
        check("post_rst_data_ack", ack, 1'b1);
        rx_q.push_back(8'h99);
        i2c_stop();
        check("post_rst_xfer_done", c_xfer - xb, 1);
        drain_rx();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
